// File: rtl/decoder_nx2n_scan.sv
// decoder_nx2n_scan: registered N-to-2^N one-hot decoder with two modes.
//   direct: D follows sel with one cycle of latency.
//   scan:   the active line walks through all 2^N lines, each held for
//           dwell+1 cycles, with a one-cycle wrap pulse on 2^N-1 -> 0.
// Optional build macro DECODER_ACTIVE_LOW_EN inverts D (active line low,
// idle/reset all-ones); idx and wrap keep their polarity.
// D, idx and wrap come straight from flops. D is stored already in its
// output polarity so that no logic sits between the flops and the port.
module decoder_nx2n_scan #(
  parameter int N       = 3,
  parameter int DWELL_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 mode,
  input  logic [N-1:0]         sel,
  input  logic [DWELL_W-1:0]   dwell,
  output logic [(1<<N)-1:0]    D,
  output logic [N-1:0]         idx,
  output logic                 wrap
);

  localparam int W = 1 << N;

`ifdef DECODER_ACTIVE_LOW_EN
  localparam logic [W-1:0] D_OFF = {W{1'b1}};
`else
  localparam logic [W-1:0] D_OFF = {W{1'b0}};
`endif

  localparam logic [DWELL_W-1:0] CNT_ONE = DWELL_W'(1);
  localparam logic [N-1:0]       IDX_ONE = N'(1);
  localparam logic [N-1:0]       IDX_MAX = {N{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  // One-hot line pattern for index i, already in output polarity.
  function automatic logic [W-1:0] line_drive(input logic [N-1:0] i);
    logic [W-1:0] v;
    v = {W{1'b0}};
    for (int b = 0; b < W; b++) begin
      if (b == int'(i)) begin
        v[b] = 1'b1;
      end else begin
        v[b] = 1'b0;
      end
    end
`ifdef DECODER_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  state_t               state_r, state_s;
  logic [W-1:0]         d_r, d_s;
  logic [N-1:0]         idx_r, idx_s;
  logic                 wrap_r, wrap_s;
  logic [DWELL_W-1:0]   cnt_r, cnt_s;
  logic [N-1:0]         step_idx_s;

  // Next index when the scan advances; wraps naturally at N bits.
  always_comb begin
    step_idx_s = idx_r + IDX_ONE;
  end

  // Next-state and next-output logic for the IDLE/DIRECT/SCAN controller.
  always_comb begin
    state_s = state_r;
    d_s     = d_r;
    idx_s   = idx_r;
    wrap_s  = 1'b0;
    cnt_s   = cnt_r;
    if (!en) begin
      // Disabled from any state: lines off, idx keeps its last value.
      state_s = ST_IDLE;
      d_s     = D_OFF;
    end else if (!mode) begin
      state_s = ST_DIRECT;
      idx_s   = sel;
      d_s     = line_drive(sel);
    end else begin
      state_s = ST_SCAN;
      case (state_r)
        ST_SCAN: begin
          if (cnt_r != {DWELL_W{1'b0}}) begin
            cnt_s = cnt_r - CNT_ONE;
          end else begin
            // Step to the next line; dwell is re-sampled on every step.
            idx_s  = step_idx_s;
            d_s    = line_drive(step_idx_s);
            cnt_s  = dwell;
            wrap_s = (idx_r == IDX_MAX);
          end
        end
        default: begin
          // Scan entry (from IDLE or DIRECT) restarts from sel.
          idx_s = sel;
          d_s   = line_drive(sel);
          cnt_s = dwell;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      d_r     <= D_OFF;
      idx_r   <= {N{1'b0}};
      wrap_r  <= 1'b0;
      cnt_r   <= {DWELL_W{1'b0}};
    end else begin
      state_r <= state_s;
      d_r     <= d_s;
      idx_r   <= idx_s;
      wrap_r  <= wrap_s;
      cnt_r   <= cnt_s;
    end
  end

  assign D    = d_r;
  assign idx  = idx_r;
  assign wrap = wrap_r;

endmodule

// File: tb/tb_decoder_nx2n_scan.sv
// Directed self-checking bench for decoder_nx2n_scan.
// dut3 uses N=3 for most scenarios; dut2 uses N=2 for the dwell=0 sweep.
// Expected D values are written active-high and converted to the build's
// polarity (DECODER_ACTIVE_LOW_EN) by pol3/pol2.
module tb_decoder_nx2n_scan;

  logic        clk;
  logic        rst, en, mode;
  logic [2:0]  sel;
  logic [15:0] dwell;
  logic [7:0]  d3;
  logic [2:0]  idx3;
  logic        wrap3;

  logic        rst2, en2, mode2;
  logic [1:0]  sel2;
  logic [15:0] dwell2;
  logic [3:0]  d2;
  logic [1:0]  idx2;
  logic        wrap2;

  int checks = 0;
  int errors = 0;

  decoder_nx2n_scan #(.N(3), .DWELL_W(16)) dut3 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .dwell(dwell),
    .D(d3), .idx(idx3), .wrap(wrap3)
  );

  decoder_nx2n_scan #(.N(2), .DWELL_W(16)) dut2 (
    .clk(clk), .rst(rst2), .en(en2), .mode(mode2), .sel(sel2), .dwell(dwell2),
    .D(d2), .idx(idx2), .wrap(wrap2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pol3(input logic [7:0] v);
`ifdef DECODER_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  function automatic logic [3:0] pol2(input logic [3:0] v);
`ifdef DECODER_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] e8;
    logic [3:0] e4;

    rst = 1'b1; en = 1'b1; mode = 1'b0; sel = 3'd0; dwell = 16'd0;
    rst2 = 1'b1; en2 = 1'b0; mode2 = 1'b0; sel2 = 2'd0; dwell2 = 16'd0;
    step();
    step();
    check("rst_D",    32'(d3),    32'(pol3(8'h00)));
    check("rst_idx",  32'(idx3),  32'd0);
    check("rst_wrap", 32'(wrap3), 32'd0);
    check("rst2_D",   32'(d2),    32'(pol2(4'h0)));

    // First edge after reset release decodes sel directly.
    rst = 1'b0; rst2 = 1'b0;
    sel = 3'd5;
    step();
    check("post_rst_D",   32'(d3),   32'(pol3(8'h20)));
    check("post_rst_idx", 32'(idx3), 32'd5);

    // Direct sweep: each sel appears one edge later, exactly one line active.
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      step();
      e8 = 8'h01 << i;
      check("direct_D",   32'(d3),   32'(pol3(e8)));
      check("direct_idx", 32'(idx3), 32'(i));
      check("direct_one", 32'($countones(pol3(d3))), 32'd1);
    end

    // Scan from 6 with dwell=2: 3 cycles per line, wrap on entering line 0.
    mode = 1'b1; sel = 3'd6; dwell = 16'd2;
    step();
    check("scan_entry_D",    32'(d3),    32'(pol3(8'h40)));
    check("scan_entry_wrap", 32'(wrap3), 32'd0);
    sel = 3'd1;   // ignored while scanning
    step(); check("scan_6b", 32'(d3), 32'(pol3(8'h40)));
    step(); check("scan_6c", 32'(d3), 32'(pol3(8'h40)));
    step(); check("scan_7a", 32'(d3), 32'(pol3(8'h80)));
    check("scan_7a_wrap", 32'(wrap3), 32'd0);
    step(); check("scan_7b", 32'(d3), 32'(pol3(8'h80)));
    step(); check("scan_7c", 32'(d3), 32'(pol3(8'h80)));
    step();
    check("scan_wrap_D",    32'(d3),    32'(pol3(8'h01)));
    check("scan_wrap_pulse", 32'(wrap3), 32'd1);
    check("scan_wrap_idx",  32'(idx3),  32'd0);
    step();
    check("scan_0b_D",    32'(d3),    32'(pol3(8'h01)));
    check("scan_0b_wrap", 32'(wrap3), 32'd0);
    step(); check("scan_0c", 32'(d3), 32'(pol3(8'h01)));
    step();
    check("scan_1a",     32'(d3),   32'(pol3(8'h02)));
    check("scan_1a_idx", 32'(idx3), 32'd1);
    step();   // mid-dwell on line 1

    // Drop en mid-dwell: lines off next cycle, idx held.
    en = 1'b0;
    step();
    check("en_off_D",    32'(d3),    32'(pol3(8'h00)));
    check("en_off_idx",  32'(idx3),  32'd1);
    check("en_off_wrap", 32'(wrap3), 32'd0);
    step();
    check("idle_D", 32'(d3), 32'(pol3(8'h00)));

    // Re-enable in scan: restart from sel with a fresh counter.
    en = 1'b1; mode = 1'b1; sel = 3'd3; dwell = 16'd2;
    step();
    check("reentry_D",   32'(d3),   32'(pol3(8'h08)));
    check("reentry_idx", 32'(idx3), 32'd3);
    step();
    check("reentry_hold", 32'(d3), 32'(pol3(8'h08)));

    // Reset mid-scan wins over everything.
    rst = 1'b1;
    step();
    check("mid_rst_D",    32'(d3),    32'(pol3(8'h00)));
    check("mid_rst_idx",  32'(idx3),  32'd0);
    check("mid_rst_wrap", 32'(wrap3), 32'd0);
    rst = 1'b0;

    // Mode switching while enabled takes effect on the next edge.
    mode = 1'b0; sel = 3'd2;
    step();
    check("sw_direct_D", 32'(d3), 32'(pol3(8'h04)));
    mode = 1'b1; sel = 3'd4; dwell = 16'd0;
    step();
    check("sw_scan_D", 32'(d3), 32'(pol3(8'h10)));
    step();
    check("sw_scan_step", 32'(d3), 32'(pol3(8'h20)));
    mode = 1'b0; sel = 3'd1;
    step();
    check("sw_back_D",   32'(d3),   32'(pol3(8'h02)));
    check("sw_back_idx", 32'(idx3), 32'd1);

    // N=2, dwell=0: one line per cycle, wrap once every 4 cycles.
    en2 = 1'b1; mode2 = 1'b1; sel2 = 2'd0; dwell2 = 16'd0;
    for (int k = 0; k < 9; k++) begin
      step();
      e4 = 4'h1 << (k % 4);
      check("n2_D",    32'(d2),    32'(pol2(e4)));
      check("n2_idx",  32'(idx2),  32'(k % 4));
      check("n2_wrap", 32'(wrap2), (k > 0 && (k % 4) == 0) ? 32'd1 : 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_nx2n_scan.md
# decoder_nx2n_scan

Parametrised, registered N-to-2^N one-hot decoder, the successor to the 3-to-8 combinational decoder. It has two operating modes. In direct mode it decodes a select input with one-cycle latency. In scan mode it walks the active output through all 2^N lines with a programmable dwell time, for multiplexed display digit select and bank strobing. It sits between control logic and digit/bank enables, and it replaces hand-instantiated fixed-width decoders.

## Interface
- `N`, default 3: select width; output width is 2^N (legal range 1..6).
- `DWELL_W`, default 16: width of the dwell counter and `dwell` input.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `en`  input  1  block enable; low forces all outputs inactive.
- `mode`  input  1  0 = direct decode, 1 = scan.
- `sel`  input  N  direct-mode select; also the scan start index.
- `dwell`  input  DWELL_W  scan step period minus one, in cycles.
- `D`  output  2^N  registered one-hot decode output.
- `idx`  output  N  index currently driven on `D`.
- `wrap`  output  1  one-cycle pulse on each scan wrap from 2^N-1 to 0.

## Operation
- The FSM has three states: IDLE, DIRECT and SCAN.
- Reset puts the block in IDLE with `D`=0, `idx`=0, `wrap`=0 and the dwell counter at 0.
- IDLE:
  - `en`=1 with `mode`=0 → DIRECT.
  - `en`=1 with `mode`=1 → SCAN.
  - Otherwise stay in IDLE with `D`=0.
- DIRECT:
  - Every cycle, `idx`<=`sel` and `D`<=1<<`sel`.
  - Exactly one bit of `D` is high.
- SCAN entry (from IDLE or DIRECT):
  - `idx`<=`sel`, `D`<=1<<`sel`, counter<=`dwell`.
- SCAN step:
  - Each cycle with counter≠0, decrement the counter.
  - When counter=0: `idx`<=`idx`+1 modulo 2^N, `D` updates to match, and counter<=current `dwell` (reloaded at every step, not only on entry).
- `wrap` pulses high in the cycle `D` moves from bit 2^N-1 to bit 0; it is low at all other times.
- `dwell`=0 gives one index per cycle, so a full sweep takes 2^N cycles. In general, each index is held for exactly `dwell`+1 cycles.
- A `mode` change while `en`=1 switches between DIRECT and SCAN on the next edge. A SCAN re-entry always restarts from `sel` with a fresh counter.
- `en` falling in any state gives IDLE on the next edge: `D`=0, `wrap`=0, and `idx` holds its last value.
- `rst` has priority over all inputs at any point mid-scan; the next cycle shows the reset values.
- `sel` changes during SCAN are ignored.

## Timing
- Latency is one cycle for every input: inputs sampled at edge k are visible on `D`/`idx` after edge k.
- `D`, `idx` and `wrap` are driven straight from flops, with no combinational path from inputs to outputs.
- `wrap` and the corresponding `D` change update on the same edge.
- Reset takes effect on the first rising edge with `rst`=1.

## Configuration
- Macro `DECODER_ACTIVE_LOW_EN`:
  - Defined: `D` is inverted, so the active line is 0 and inactive/reset/IDLE is all-ones. `idx` and `wrap` are unchanged.
  - Undefined (default): `D` is active-high, and reset/IDLE gives all-zeros.

## Test plan
- Reset, N=3: hold `rst`=1 for 2 cycles with `en`=1 → `D`=8'h00, `idx`=0, `wrap`=0. First edge after release with `mode`=0, `sel`=5 → `D`=8'h20.
- Direct sweep, N=3: `en`=1, `mode`=0, `sel`=0..7 one per cycle → `D` = 8'h01, 02, 04 … 80, each one cycle after `sel`, with exactly one bit high.
- Scan with dwell, N=3: `mode`=1, `sel`=6, `dwell`=2 → `D`=8'h40 for 3 cycles, then 8'h80 for 3 cycles, then 8'h01 with `wrap`=1 for that first cycle only.
- Scan at dwell=0, N=2: `sel`=0 → `D` = 1,2,4,8,1 on consecutive cycles, with `wrap` high exactly once per 4 cycles.
- Mid-operation events:
  - Drop `en` mid-dwell → `D`=0 the next cycle and `idx` held.
  - Re-enable in scan with `sel`=3 → restart at `D`=8'h08.
  - Assert `rst` mid-scan → `D`=0, `idx`=0.
- Build with `DECODER_ACTIVE_LOW_EN`, `sel`=2 direct → `D`=8'hFB; reset/IDLE → 8'hFF.
